ysyx_040750_pc_redirect_ctrl: RTL and testbench

Sequencing controller for the next-PC path of the ysyx_040750 pipelined core. Arbitrates between trap/interrupt redirects, execute-stage branch/jump redirects, fence.i sequencing and the default sequential PC, then presents exactly one dnpc to IF under a valid/ready handshake. Holds a pending redirect across IF back-pressure, drives the pipeline flush, sequences the I-cache invalidate for fence.i, and counts redirect stall cycles. Sits between the CSR/EX/ID stages and the PC register.

---
 rtl/ysyx_040750_pc_ctrl_pkg.sv | 20 ++
 rtl/ysyx_040750_pc_redirect_ctrl_redirect_arb.sv | 34 +++
 rtl/ysyx_040750_pc_redirect_ctrl.sv | 143 ++++++++++++++
 tb/tb_ysyx_040750_pc_redirect_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040750_pc_ctrl_pkg.sv
// Shared types and constants for the ysyx_040750 next-PC redirect controller.
package ysyx_040750_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HOLD      = 2'd2,
        ST_FENCE_INV = 2'd3
    } pc_state_e;

    localparam logic [31:0] RST_PC_DEF = 32'h8000_0000;

    // Request indices into the arbiter grant vector, highest priority first.
    localparam int unsigned REQ_TRAP   = 0;
    localparam int unsigned REQ_BR     = 1;
    localparam int unsigned REQ_FENCEI = 2;
    localparam int unsigned REQ_SEQ    = 3;
    localparam int unsigned REQ_N      = 4;

endpackage

// File: rtl/ysyx_040750_pc_redirect_ctrl_redirect_arb.sv
// Fixed-priority next-PC picker: trap > branch > fence.i > sequential.
module ysyx_040750_redirect_arb
    import ysyx_040750_pc_ctrl_pkg::*;
(
    input  logic             trap_valid,
    input  logic [31:0]      trap_pc,
    input  logic             br_valid,
    input  logic [31:0]      br_target,
    input  logic             fencei_valid,
    input  logic [31:0]      fencei_pc,
    input  logic             seq_valid,
    input  logic [31:0]      snpc,
    output logic [REQ_N-1:0] grant,
    output logic [31:0]      sel_pc
);

    always_comb begin
        grant  = '0;
        sel_pc = snpc;
        if (trap_valid) begin
            grant[REQ_TRAP] = 1'b1;
            sel_pc          = trap_pc;
        end else if (br_valid) begin
            grant[REQ_BR] = 1'b1;
            sel_pc        = {br_target[31:1], 1'b0};
        end else if (fencei_valid) begin
            grant[REQ_FENCEI] = 1'b1;
            sel_pc            = fencei_pc + 32'd4;
        end else if (seq_valid) begin
            grant[REQ_SEQ] = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_040750_pc_redirect_ctrl.sv
// Next-PC sequencing controller: arbitrates redirects, holds dnpc across IF stalls.
// Define YSYX_040750_FENCEI_EN to sequence an I-cache invalidate for fence.i.
module ysyx_040750_pc_redirect_ctrl
    import ysyx_040750_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RST_PC = RST_PC_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_trap_valid,
    input  logic [31:0]      I_trap_pc,
    input  logic             I_br_valid,
    input  logic [31:0]      I_br_target,
    input  logic             I_fencei_valid,
    input  logic [31:0]      I_fencei_pc,
    input  logic             I_fencei_done,
    input  logic             I_seq_valid,
    input  logic [31:0]      I_snpc,
    input  logic             I_if_ready,
    output logic             O_pc_valid,
    output logic [31:0]      O_dnpc,
    output logic             O_trap_ack,
    output logic             O_br_ack,
    output logic             O_fencei_ack,
    output logic             O_flush,
    output logic             O_fencei_inv,
    output logic [CNT_W-1:0] O_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pc_state_e         state_q, state_nxt;
    logic [31:0]       pend_q, pend_nxt;
    logic              flush_q, flush_nxt;
    logic [CNT_W-1:0]  stall_q;
    logic [REQ_N-1:0]  grant;
    logic [31:0]       sel_pc;

`ifndef YSYX_040750_FENCEI_EN
    logic unused_fencei_done;
    assign unused_fencei_done = I_fencei_done;
`endif

    ysyx_040750_redirect_arb u_arb (
        .trap_valid   (I_trap_valid),
        .trap_pc      (I_trap_pc),
        .br_valid     (I_br_valid),
        .br_target    (I_br_target),
        .fencei_valid (I_fencei_valid),
        .fencei_pc    (I_fencei_pc),
        .seq_valid    (I_seq_valid),
        .snpc         (I_snpc),
        .grant        (grant),
        .sel_pc       (sel_pc)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_BOOT;
            pend_q  <= '0;
            flush_q <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_nxt;
            pend_q  <= pend_nxt;
            flush_q <= flush_nxt;
            if (state_q == ST_HOLD && !I_if_ready && stall_q != '1) begin
                stall_q <= stall_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        pend_nxt     = pend_q;
        flush_nxt    = 1'b0;
        O_pc_valid   = 1'b0;
        O_dnpc       = pend_q;
        O_trap_ack   = 1'b0;
        O_br_ack     = 1'b0;
        O_fencei_ack = 1'b0;
        O_fencei_inv = 1'b0;
        case (state_q)
            ST_BOOT: begin
                O_pc_valid = 1'b1;
                O_dnpc     = RST_PC;
                if (I_if_ready) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Sequential fetch only drives IF when no redirect wins this cycle.
                O_pc_valid = grant[REQ_SEQ];
                O_dnpc     = sel_pc;
                if (grant[REQ_TRAP] || grant[REQ_BR]) begin
                    O_trap_ack = grant[REQ_TRAP];
                    O_br_ack   = grant[REQ_BR];
                    pend_nxt   = sel_pc;
                    flush_nxt  = 1'b1;
                    state_nxt  = ST_HOLD;
                end else if (grant[REQ_FENCEI]) begin
                    O_fencei_ack = 1'b1;
                    pend_nxt     = sel_pc;
                    flush_nxt    = 1'b1;
`ifdef YSYX_040750_FENCEI_EN
                    state_nxt    = ST_FENCE_INV;
`else
                    state_nxt    = ST_HOLD;
`endif
                end
            end
            ST_HOLD: begin
                O_pc_valid = 1'b1;
                O_dnpc     = pend_q;
                // A trap overrides the pending target even if IF takes the old one now.
                if (I_trap_valid) begin
                    O_trap_ack = 1'b1;
                    pend_nxt   = I_trap_pc;
                    flush_nxt  = 1'b1;
                end else if (I_if_ready) begin
                    state_nxt = ST_RUN;
                end
            end
`ifdef YSYX_040750_FENCEI_EN
            ST_FENCE_INV: begin
                O_fencei_inv = 1'b1;
                if (I_trap_valid) begin
                    O_trap_ack = 1'b1;
                    pend_nxt   = I_trap_pc;
                    flush_nxt  = 1'b1;
                end
                if (I_fencei_done) state_nxt = ST_HOLD;
            end
`endif
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    assign O_flush     = flush_q;
    assign O_stall_cnt = stall_q;

endmodule

// File: tb/tb_ysyx_040750_pc_redirect_ctrl.sv
// Randomized and directed bench for ysyx_040750_pc_redirect_ctrl against a behavioural model.
module tb_ysyx_040750_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             I_clk = 1'b0;
    logic             I_rst_n;
    logic             I_trap_valid, I_br_valid, I_fencei_valid, I_fencei_done, I_seq_valid, I_if_ready;
    logic [31:0]      I_trap_pc, I_br_target, I_fencei_pc, I_snpc;
    logic             O_pc_valid, O_trap_ack, O_br_ack, O_fencei_ack, O_flush, O_fencei_inv;
    logic [31:0]      O_dnpc;
    logic [CNT_W-1:0] O_stall_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ysyx_040750_pc_redirect_ctrl #(.RST_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n),
        .I_trap_valid(I_trap_valid), .I_trap_pc(I_trap_pc),
        .I_br_valid(I_br_valid), .I_br_target(I_br_target),
        .I_fencei_valid(I_fencei_valid), .I_fencei_pc(I_fencei_pc),
        .I_fencei_done(I_fencei_done),
        .I_seq_valid(I_seq_valid), .I_snpc(I_snpc),
        .I_if_ready(I_if_ready),
        .O_pc_valid(O_pc_valid), .O_dnpc(O_dnpc),
        .O_trap_ack(O_trap_ack), .O_br_ack(O_br_ack), .O_fencei_ack(O_fencei_ack),
        .O_flush(O_flush), .O_fencei_inv(O_fencei_inv), .O_stall_cnt(O_stall_cnt)
    );

    always #5 I_clk = ~I_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: "where is the fetch stream" expressed as boot / waiting-on-invalidate /
    // target-pending flags plus a remembered target.
    bit          m_boot, m_inv, m_hold, m_flush;
    logic [31:0] m_pc;
    int unsigned m_cnt;
    bit          e_valid, e_tack, e_back, e_fack, e_inv;
    logic [31:0] e_dnpc;

    task automatic model_reset();
        m_boot = 1; m_inv = 0; m_hold = 0; m_flush = 0; m_pc = '0; m_cnt = 0;
    endtask

    task automatic model_outputs();
        e_valid = 0; e_dnpc = '0; e_tack = 0; e_back = 0; e_fack = 0; e_inv = 0;
        if (m_boot) begin
            e_valid = 1; e_dnpc = RST_PC;
        end else if (m_inv) begin
            e_inv = 1; e_tack = I_trap_valid;
        end else if (m_hold) begin
            e_valid = 1; e_dnpc = m_pc; e_tack = I_trap_valid;
        end else begin
            e_tack = I_trap_valid;
            e_back = !I_trap_valid && I_br_valid;
            e_fack = !I_trap_valid && !I_br_valid && I_fencei_valid;
            if (!(e_tack || e_back || e_fack)) begin
                e_valid = I_seq_valid; e_dnpc = I_snpc;
            end
        end
    endtask

    task automatic model_update();
        bit nf;
        nf = 0;
        if (!I_rst_n) begin
            model_reset();
            return;
        end
        if (m_boot) begin
            if (I_if_ready) m_boot = 0;
        end else if (m_inv) begin
            if (I_trap_valid) begin m_pc = I_trap_pc; nf = 1; end
            if (I_fencei_done) begin m_inv = 0; m_hold = 1; end
        end else if (m_hold) begin
            if (!I_if_ready && m_cnt < CNT_MAX) m_cnt++;
            if (I_trap_valid) begin m_pc = I_trap_pc; nf = 1; end
            else if (I_if_ready) m_hold = 0;
        end else begin
            if (I_trap_valid) begin
                m_pc = I_trap_pc; m_hold = 1; nf = 1;
            end else if (I_br_valid) begin
                m_pc = I_br_target & 32'hFFFF_FFFE; m_hold = 1; nf = 1;
            end else if (I_fencei_valid) begin
                m_pc = I_fencei_pc + 32'd4; nf = 1;
`ifdef YSYX_040750_FENCEI_EN
                m_inv = 1;
`else
                m_hold = 1;
`endif
            end
        end
        m_flush = nf;
    endtask

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge I_clk);
        model_outputs();
        check("pc_valid", {31'b0, O_pc_valid}, {31'b0, e_valid});
        if (e_valid) check("dnpc", O_dnpc, e_dnpc);
        check("trap_ack", {31'b0, O_trap_ack}, {31'b0, e_tack});
        check("br_ack", {31'b0, O_br_ack}, {31'b0, e_back});
        check("fencei_ack", {31'b0, O_fencei_ack}, {31'b0, e_fack});
        check("flush", {31'b0, O_flush}, {31'b0, m_flush});
        check("fencei_inv", {31'b0, O_fencei_inv}, {31'b0, e_inv});
        check("stall_cnt", {{(32-CNT_W){1'b0}}, O_stall_cnt}, m_cnt);
        @(posedge I_clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        I_trap_valid = 0; I_br_valid = 0; I_fencei_valid = 0; I_fencei_done = 0;
        I_seq_valid = 1; I_if_ready = 1;
        I_trap_pc = '0; I_br_target = '0; I_fencei_pc = '0; I_snpc = 32'h8000_0004;
    endtask

    initial begin
        int unsigned waited;
        I_rst_n = 0;
        idle_inputs();
        model_reset();
        @(posedge I_clk); #1;
        step();
        check("rst_dnpc", O_dnpc, RST_PC);
        I_rst_n = 1;

        // Boot address then sequential passthrough.
        step();
        I_snpc = 32'h8000_0008;
        step();

        // Branch with odd target and three stalled IF cycles.
        I_br_valid = 1; I_br_target = 32'h8000_0101; I_if_ready = 0;
        step();
        I_br_valid = 0;
        repeat (3) step();
        check("br_held_dnpc", O_dnpc, 32'h8000_0100);
        check("br_stall_cnt", {28'b0, O_stall_cnt}, 32'd3);
        I_if_ready = 1;
        step();

        // Trap and branch together: trap wins.
        I_trap_valid = 1; I_trap_pc = 32'h8000_0200; I_br_valid = 1; I_br_target = 32'h8000_0300;
        step();
        check("trap_win_dnpc", O_dnpc, 32'h8000_0200);
        I_trap_valid = 0; I_br_valid = 0;
        step();

        // Trap arriving while a branch target is held.
        I_br_valid = 1; I_br_target = 32'h8000_0300; I_if_ready = 0;
        step();
        I_br_valid = 0;
        step();
        I_trap_valid = 1; I_trap_pc = 32'h8000_0400;
        step();
        I_trap_valid = 0; I_if_ready = 1;
        step();
        step();

        // fence.i with a five-cycle invalidate.
        I_fencei_valid = 1; I_fencei_pc = 32'h8000_0010;
        step();
        I_fencei_valid = 0;
        repeat (4) step();
        I_fencei_done = 1;
        step();
        I_fencei_done = 0;
        repeat (2) step();

        // fence.i at the top of the address space wraps to zero.
        I_fencei_valid = 1; I_fencei_pc = 32'hFFFF_FFFC; I_seq_valid = 0;
        step();
        I_fencei_valid = 0; I_fencei_done = 1; I_if_ready = 0;
        waited = 0;
        while (!O_pc_valid && waited < 10) begin
            step();
            waited++;
        end
        check("fencei_wrap_dnpc", O_dnpc, 32'h0000_0000);
        I_fencei_done = 0; I_if_ready = 1; I_seq_valid = 1;
        step();

        // Randomized traffic; frequent IF stalls drive the counter into saturation.
        for (int i = 0; i < 3000; i++) begin
            I_trap_valid   = ($urandom_range(0, 11) == 0);
            I_br_valid     = ($urandom_range(0, 4) == 0);
            I_fencei_valid = ($urandom_range(0, 7) == 0);
            I_fencei_done  = ($urandom_range(0, 2) == 0);
            I_seq_valid    = ($urandom_range(0, 3) != 0);
            I_if_ready     = ($urandom_range(0, 9) < 6);
            I_trap_pc      = $urandom;
            I_br_target    = $urandom;
            I_fencei_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            I_snpc         = $urandom;
            step();
        end
        check("stall_saturated", {28'b0, O_stall_cnt}, CNT_MAX);

        // Asynchronous reset in the middle of a held redirect.
        idle_inputs();
        step();
        I_br_valid = 1; I_br_target = 32'h8000_0500; I_if_ready = 0;
        step();
        I_br_valid = 0;
        step();
        #2;
        I_rst_n = 0;
        model_reset();
        #1;
        check("mid_rst_valid", {31'b0, O_pc_valid}, 32'd1);
        check("mid_rst_dnpc", O_dnpc, RST_PC);
        check("mid_rst_flush", {31'b0, O_flush}, 32'd0);
        check("mid_rst_stall", {28'b0, O_stall_cnt}, 32'd0);
        check("mid_rst_inv", {31'b0, O_fencei_inv}, 32'd0);
        @(posedge I_clk); #1;
        step();
        I_rst_n = 1; I_if_ready = 1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
